mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_timer.sv | 41 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  // Instruction handed back when the memory never answers an instruction fetch.
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'hC000;

  // Round-robin choice: on a tie the port that did not win last time gets the bus.
  function automatic grant_e pickGrant(input logic instrStb,
                                       input logic dataStb,
                                       input grant_e lastGrant);
    grant_e result;
    if (instrStb && dataStb) begin
      result = (lastGrant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    end else if (dataStb) begin
      result = GNT_DATA;
    end else begin
      result = GNT_INSTR;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Counts BUSY cycles and flags the cycle in which the wait limit is reached.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // The counter only ever holds 0..TIMEOUT-1, the number of BUSY cycles already completed.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expired is asserted during the TIMEOUT-th BUSY cycle so the caller can act on that edge.
  assign expired_o = enable_i && (count_q == LAST);

  // Next count: restart outside BUSY, advance while waiting, stop once expired.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single memory master port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned     AW        = 16,
  parameter int unsigned     DW        = 16,
  parameter int unsigned     TIMEOUT   = 16,
  parameter logic [DW-1:0]   NOP_INSTR = DW'(NOP_INSTR_DEFAULT)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [AW-1:0] instr_addr_i,
  input  logic          instr_stb_i,
  input  logic          instr_we_i,
  output logic [DW-1:0] instr_data_o,
  output logic          instr_ack_o,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_data_i,
  input  logic          data_stb_i,
  input  logic          data_we_i,
  output logic [DW-1:0] data_data_o,
  output logic          data_ack_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_data_o,
  input  logic [DW-1:0] mem_data_i,
  output logic          mem_stb_o,
  output logic          mem_we_o,
  input  logic          mem_ack_i,
  output logic          bus_err_o
);

  state_e        state_q, state_d;
  grant_e        lastGrant_q, lastGrant_d;
  grant_e        arbGrant;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memData_q, memData_d;
  logic          memWe_q, memWe_d;
  logic [DW-1:0] instrData_q, instrData_d;
  logic [DW-1:0] dataData_q, dataData_d;
  logic          busErr_q, busErr_d;
  logic          timerExpired;
  logic          unusedInstrWe;

  // The instruction port is read-only; its write strobe is accepted but has no effect.
  assign unusedInstrWe = instr_we_i;

  assign arbGrant = pickGrant(instr_stb_i, data_stb_i, lastGrant_q);

  // Wait-limit counter runs only while a transaction is outstanding.
  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .clear_i   (state_q != ST_BUSY),
    .enable_i  (state_q == ST_BUSY),
    .expired_o (timerExpired)
  );

  // Next-state and datapath: grant in IDLE, wait for memory in BUSY, hand back one ack in RESP.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    memAddr_d   = memAddr_q;
    memData_d   = memData_q;
    memWe_d     = memWe_q;
    instrData_d = instrData_q;
    dataData_d  = dataData_q;
    busErr_d    = busErr_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_stb_i || data_stb_i) begin
          lastGrant_d = arbGrant;
          state_d     = ST_BUSY;
          if (arbGrant == GNT_DATA) begin
            memAddr_d = data_addr_i;
            memData_d = data_data_i;
            memWe_d   = data_we_i;
          end else begin
            memAddr_d = instr_addr_i;
            memData_d = '0;
            memWe_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d = ST_RESP;
          if (lastGrant_q == GNT_DATA) begin
            dataData_d = mem_data_i;
          end else begin
            instrData_d = mem_data_i;
          end
        end else if (timerExpired) begin
          state_d  = ST_RESP;
          busErr_d = 1'b1;
          if (lastGrant_q == GNT_DATA) begin
            dataData_d = '0;
          end else begin
            instrData_d = NOP_INSTR;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= GNT_INSTR;
      memAddr_q   <= '0;
      memData_q   <= '0;
      memWe_q     <= 1'b0;
      instrData_q <= '0;
      dataData_q  <= '0;
      busErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      memAddr_q   <= memAddr_d;
      memData_q   <= memData_d;
      memWe_q     <= memWe_d;
      instrData_q <= instrData_d;
      dataData_q  <= dataData_d;
      busErr_q    <= busErr_d;
    end
  end

  assign mem_addr_o   = memAddr_q;
  assign mem_data_o   = memData_q;
  assign mem_we_o     = memWe_q;
  assign mem_stb_o    = (state_q == ST_BUSY);
  assign instr_ack_o  = (state_q == ST_RESP) && (lastGrant_q == GNT_INSTR);
  assign data_ack_o   = (state_q == ST_RESP) && (lastGrant_q == GNT_DATA);
  assign instr_data_o = instrData_q;
  assign data_data_o  = dataData_q;
  assign bus_err_o    = busErr_q;

endmodule
